// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline control block:
//   - mem_state_e : memory-access FSM state encoding (IDLE, WAIT, ERR)
//   - PC_REG      : register number of the program counter; never takes part
//                   in RAW hazard matching
//   - src_match() : one producer/consumer RAW comparison
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_e;

    localparam logic [3:0] PC_REG = 4'hF;

    // A source matches a producer only when the producer actually writes back
    // and the register is not the PC (the PC is never tracked for hazards).
    function automatic logic src_match(input logic [3:0] src,
                                       input logic [3:0] dest,
                                       input logic       wb_en);
        return wb_en && (src == dest) && (src != PC_REG);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational RAW hazard detection for the ID stage.
//
// Configuration macro: PIPELINE_CTRL_FORWARDING_EN
//   undefined : any EXE- or MEM-stage writeback to a used source is a hazard.
//   defined   : forwarding covers ALU results, so only a load in EXE whose
//               destination is a used source (load-use) is a hazard.
//
// Ports:
//   src1, src2    in  ID-stage source register numbers
//   two_src       in  ID instruction also reads src2
//   exe_wb_en     in  EXE-stage writeback enable
//   exe_dest      in  EXE-stage destination register
//   mem_wb_en     in  MEM-stage writeback enable
//   mem_dest      in  MEM-stage destination register
//   exe_mem_r_en  in  EXE-stage instruction is a load
//   hz            out hazard present this cycle
// ----------------------------------------------------------------------------
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       two_src,
    input  logic       exe_wb_en,
    input  logic [3:0] exe_dest,
    input  logic       mem_wb_en,
    input  logic [3:0] mem_dest,
    input  logic       exe_mem_r_en,
    output logic       hz
);

`ifdef PIPELINE_CTRL_FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time; MEM results are
    // always available through the bypass network.
    logic exe_load_wb;
    logic unused_mem_stage;

    assign exe_load_wb      = exe_mem_r_en && exe_wb_en;
    assign unused_mem_stage = mem_wb_en ^ (^mem_dest);

    assign hz = src_match(src1, exe_dest, exe_load_wb) ||
                (two_src && src_match(src2, exe_dest, exe_load_wb));
`else
    logic unused_load_flag;

    assign unused_load_flag = exe_mem_r_en;

    assign hz = src_match(src1, exe_dest, exe_wb_en) ||
                src_match(src1, mem_dest, mem_wb_en) ||
                (two_src && (src_match(src2, exe_dest, exe_wb_en) ||
                             src_match(src2, mem_dest, mem_wb_en)));
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
// Pipeline stall/flush controller: combines a memory-access wait FSM, branch
// flushes and RAW hazard bubbles into the per-stage freeze/flush controls,
// and keeps a saturating count of stalled cycles.
//
// Configuration macro: PIPELINE_CTRL_FORWARDING_EN (see hazard_detect).
//
// Parameters:
//   MEM_TIMEOUT  WAIT cycles tolerated before the sticky memory error
//   CNT_W        width of the stall performance counter
//
// Ports:
//   clk             in  clock, rising edge
//   rst             in  synchronous reset, active low
//   src1, src2      in  ID-stage source registers; two_src = src2 used
//   exe_wb_en/dest  in  EXE-stage writeback
//   mem_wb_en/dest  in  MEM-stage writeback
//   exe_mem_r_en    in  EXE-stage instruction is a load
//   branch_taken    in  EXE-stage branch resolved taken
//   mem_req         in  MEM-stage access pending
//   mem_ready       in  memory completes this cycle
//   freeze_pc_ifid  out hold PC and IF/ID
//   flush_ifid      out zero IF/ID
//   flush_idexe     out zero ID/EXE
//   freeze_all      out hold every stage register
//   mem_err         out sticky memory timeout
//   stall_cnt       out saturating stall/bubble cycle count
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd64,
    parameter int         CNT_W       = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             exe_wb_en,
    input  logic [3:0]       exe_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             exe_mem_r_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc_ifid,
    output logic             flush_ifid,
    output logic             flush_idexe,
    output logic             freeze_all,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    mem_state_e state, state_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       mem_busy;
    logic       hz;
    logic       stall_inc;

    hazard_detect u_hazard_detect (
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .exe_mem_r_en (exe_mem_r_en),
        .hz           (hz)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // mem_busy is asserted already in the IDLE cycle that raises the request,
    // and dropped in the cycle mem_ready arrives, so the pipeline resumes with
    // zero latency.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        mem_busy    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !mem_ready) begin
                    mem_busy    = 1'b1;
                    state_nx    = WAIT;
                    wait_cnt_nx = 8'd0;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nx = IDLE;
                end else begin
                    mem_busy    = 1'b1;
                    wait_cnt_nx = wait_cnt + 8'd1;
                    if (wait_cnt == (MEM_TIMEOUT - 8'd1))
                        state_nx = ERR;
                end
            end
            ERR: begin
                mem_busy = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Priority: memory stall, then branch flush, then hazard bubble.
    always_comb begin
        freeze_all     = 1'b0;
        freeze_pc_ifid = 1'b0;
        flush_ifid     = 1'b0;
        flush_idexe    = 1'b0;
        if (rst) begin
            if (mem_busy) begin
                freeze_all     = 1'b1;
                freeze_pc_ifid = 1'b1;
            end else if (branch_taken) begin
                flush_ifid  = 1'b1;
                flush_idexe = 1'b1;
            end else if (hz) begin
                freeze_pc_ifid = 1'b1;
                flush_idexe    = 1'b1;
            end
        end
    end

    assign stall_inc = freeze_all || freeze_pc_ifid;
    assign mem_err   = (state == ERR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Scoreboard bench for pipeline_ctrl. Two instances share the stimulus: one
// with default parameters, one with MEM_TIMEOUT=4 / CNT_W=4 so the timeout
// and counter saturation corners are reachable. A reference model derives
// the expected outputs of every cycle and queues them; a monitor pops and
// compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    typedef struct packed {
        logic       rst;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       two_src;
        logic       exe_wb_en;
        logic [3:0] exe_dest;
        logic       mem_wb_en;
        logic [3:0] mem_dest;
        logic       exe_mem_r_en;
        logic       branch_taken;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    typedef struct packed {
        logic        fpc;
        logic        fif;
        logic        fide;
        logic        fa;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, two_src, exe_wb_en, mem_wb_en, exe_mem_r_en;
    logic branch_taken, mem_req, mem_ready;
    logic [3:0] src1, src2, exe_dest, mem_dest;

    logic        b_fpc, b_fif, b_fide, b_fa, b_err;
    logic [15:0] b_cnt;
    logic        s_fpc, s_fif, s_fide, s_fa, s_err;
    logic [3:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t q_big[$];
    exp_t q_small[$];

    // Reference state per instance: 0 = idle, 1 = waiting, 2 = error.
    int phase[2]   = '{0, 0};
    int waited[2]  = '{0, 0};
    int cnt[2]     = '{0, 0};
    int timeout[2] = '{64, 4};
    int cmax[2]    = '{65535, 15};

    always #5 clk = ~clk;

    pipeline_ctrl dut_big (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .exe_mem_r_en(exe_mem_r_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc_ifid(b_fpc), .flush_ifid(b_fif), .flush_idexe(b_fide),
        .freeze_all(b_fa), .mem_err(b_err), .stall_cnt(b_cnt)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(8'd4), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .exe_mem_r_en(exe_mem_r_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc_ifid(s_fpc), .flush_ifid(s_fif), .flush_idexe(s_fide),
        .freeze_all(s_fa), .mem_err(s_err), .stall_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Which used source registers have an in-flight producer that cannot be
    // bypassed in time.
    function automatic bit ref_hazard(input stim_t s);
        logic [3:0] used[$];
        bit found = 0;
        used.push_back(s.src1);
        if (s.two_src) used.push_back(s.src2);
        foreach (used[k]) begin
            if (used[k] == 4'hF) continue;
`ifdef PIPELINE_CTRL_FORWARDING_EN
            if (s.exe_mem_r_en && s.exe_wb_en && s.exe_dest == used[k]) found = 1;
`else
            if (s.exe_wb_en && s.exe_dest == used[k]) found = 1;
            if (s.mem_wb_en && s.mem_dest == used[k]) found = 1;
`endif
        end
        return found;
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs for this
    // cycle, then advance the reference to the state after the next edge.
    task automatic step(input stim_t s);
        bit hz, busy;
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst; src1 = s.src1; src2 = s.src2; two_src = s.two_src;
        exe_wb_en = s.exe_wb_en; exe_dest = s.exe_dest;
        mem_wb_en = s.mem_wb_en; mem_dest = s.mem_dest;
        exe_mem_r_en = s.exe_mem_r_en; branch_taken = s.branch_taken;
        mem_req = s.mem_req; mem_ready = s.mem_ready;
        hz = ref_hazard(s);
        for (int i = 0; i < 2; i++) begin
            e = '0;
            e.err = (phase[i] == 2);
            e.cnt = 16'(cnt[i]);
            if (!s.rst) begin
                phase[i] = 0; waited[i] = 0; cnt[i] = 0;
            end else begin
                busy = (phase[i] == 2) ||
                       (phase[i] == 0 && s.mem_req && !s.mem_ready) ||
                       (phase[i] == 1 && !s.mem_ready);
                if (busy) begin
                    e.fa = 1; e.fpc = 1;
                end else if (s.branch_taken) begin
                    e.fif = 1; e.fide = 1;
                end else if (hz) begin
                    e.fpc = 1; e.fide = 1;
                end
                if ((e.fa || e.fpc) && cnt[i] < cmax[i]) cnt[i]++;
                if (phase[i] == 0 && s.mem_req && !s.mem_ready) begin
                    phase[i] = 1; waited[i] = 0;
                end else if (phase[i] == 1) begin
                    if (s.mem_ready) phase[i] = 0;
                    else begin
                        waited[i]++;
                        if (waited[i] >= timeout[i]) phase[i] = 2;
                    end
                end
            end
            if (i == 0) q_big.push_back(e);
            else q_small.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_big.size() > 0) begin
                e = q_big.pop_front();
                chk("big.freeze_pc_ifid", 16'(b_fpc), 16'(e.fpc));
                chk("big.flush_ifid", 16'(b_fif), 16'(e.fif));
                chk("big.flush_idexe", 16'(b_fide), 16'(e.fide));
                chk("big.freeze_all", 16'(b_fa), 16'(e.fa));
                chk("big.mem_err", 16'(b_err), 16'(e.err));
                chk("big.stall_cnt", b_cnt, e.cnt);
            end
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                chk("small.freeze_pc_ifid", 16'(s_fpc), 16'(e.fpc));
                chk("small.flush_ifid", 16'(s_fif), 16'(e.fif));
                chk("small.flush_idexe", 16'(s_fide), 16'(e.fide));
                chk("small.freeze_all", 16'(s_fa), 16'(e.fa));
                chk("small.mem_err", 16'(s_err), 16'(e.err));
                chk("small.stall_cnt", 16'(s_cnt), e.cnt);
            end
        end
    end

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return 4'hF;
        return 4'($urandom_range(0, 3));
    endfunction

    function automatic stim_t idle_stim();
        stim_t s = '0;
        s.rst = 1'b1;
        s.src1 = 4'd1; s.src2 = 4'd2;
        return s;
    endfunction

    initial begin : driver
        stim_t s, rs;
        rst = 1'b0; src1 = '0; src2 = '0; two_src = 0; exe_wb_en = 0;
        exe_dest = '0; mem_wb_en = 0; mem_dest = '0; exe_mem_r_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk);

        rs = idle_stim(); rs.rst = 1'b0;

        // Reset state, then a plain EXE-stage RAW on src1.
        step(rs);
        s = idle_stim(); s.src1 = 4'd3; s.exe_wb_en = 1; s.exe_dest = 4'd3;
        step(s);
        // Same with and without a load in EXE.
        s.exe_mem_r_en = 1; step(s);
        s.exe_mem_r_en = 0; step(s);
        // MEM-stage match on src2, and the PC never matching.
        s = idle_stim(); s.two_src = 1; s.src2 = 4'd5; s.mem_wb_en = 1; s.mem_dest = 4'd5;
        step(s);
        s = idle_stim(); s.src1 = 4'hF; s.exe_wb_en = 1; s.exe_dest = 4'hF; s.exe_mem_r_en = 1;
        step(s);
        // Branch taken together with a hazard.
        s = idle_stim(); s.src1 = 4'd3; s.exe_wb_en = 1; s.exe_dest = 4'd3;
        s.exe_mem_r_en = 1; s.branch_taken = 1;
        step(s);

        // Memory access held off five cycles then completing.
        step(rs);
        s = idle_stim(); s.mem_req = 1;
        repeat (5) step(s);
        s.mem_ready = 1; step(s);
        @(negedge clk); #1;
        chk("mem_wait.stall_cnt", b_cnt, 16'd5);
        chk("mem_wait.freeze_all_ready", 16'(b_fa), 16'd0);
        s = idle_stim(); step(s);

        // Memory never answers: timeout into the sticky error, then reset.
        step(rs);
        s = idle_stim(); s.mem_req = 1;
        repeat (8) step(s);
        s = idle_stim(); s.branch_taken = 1;
        step(s);
        @(negedge clk); #1;
        chk("timeout.mem_err", 16'(s_err), 16'd1);
        step(rs);
        step(idle_stim());

        // Continuous hazard for 20 cycles drives the narrow counter to saturation.
        step(rs);
        s = idle_stim(); s.src1 = 4'd3; s.exe_wb_en = 1; s.exe_dest = 4'd3; s.exe_mem_r_en = 1;
        repeat (20) step(s);
        step(idle_stim());
        @(negedge clk); #1;
        chk("saturate.small_stall_cnt", 16'(s_cnt), 16'hF);
        chk("saturate.big_stall_cnt", b_cnt, 16'd20);

        // Randomized traffic, first with responsive memory, then sluggish.
        for (int n = 0; n < 3000; n++) begin
            s.rst          = ($urandom_range(0, 39) != 0);
            s.src1         = rand_reg();
            s.src2         = rand_reg();
            s.two_src      = 1'($urandom);
            s.exe_wb_en    = 1'($urandom);
            s.exe_dest     = rand_reg();
            s.mem_wb_en    = 1'($urandom);
            s.mem_dest     = rand_reg();
            s.exe_mem_r_en = 1'($urandom);
            s.branch_taken = ($urandom_range(0, 5) == 0);
            s.mem_req      = ($urandom_range(0, 3) == 0);
            s.mem_ready    = (n < 1500) ? ($urandom_range(0, 1) == 0)
                                        : ($urandom_range(0, 15) == 0);
            step(s);
        end

        for (int k = 0; k < 5 && (q_big.size() > 0 || q_small.size() > 0); k++)
            @(negedge clk);
        #2;
        checks++;
        if (q_big.size() > 0 || q_small.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d/%0d entries left, required 0", q_big.size(), q_small.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
